// File: rtl/seq_detector_param.sv
// Serial pattern detector with a runtime-programmable pattern and length.
// Supports overlapping and non-overlapping modes and a saturating match counter.
module seq_detector_param #(
  parameter int unsigned         MAX_LEN     = 8,
  parameter int unsigned         LEN_W       = $clog2(MAX_LEN + 1),
  parameter int unsigned         CNT_W       = 8,
  parameter logic [MAX_LEN-1:0]  DEF_PATTERN = MAX_LEN'(8'b0010_0111),
  parameter int unsigned         DEF_LEN     = 6,
  parameter bit                  DEF_OVERLAP = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               in,
  input  logic               in_valid,
  output logic               match,
  output logic [CNT_W-1:0]   match_count,
  output logic               count_sat
);

  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               ovl_q, ovl_d;
  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic               match_d;
  logic [CNT_W-1:0]   count_d;

  logic [MAX_LEN-1:0] nh_c;
  logic [LEN_W-1:0]   nf_c;
  logic               hit_c;

  // Candidate history/fill for an accepted bit and the resulting hit.
  always_comb begin
    nh_c  = {hist_q[MAX_LEN-2:0], in};
    nf_c  = (fill_q >= LEN_MAX) ? LEN_MAX : fill_q + LEN_W'(1);
    hit_c = (len_q != '0) && (len_q <= LEN_MAX) && (nf_c >= len_q);
    for (int unsigned i = 0; i < MAX_LEN; i++) begin
      if ((LEN_W'(i) < len_q) && (nh_c[i] != pat_q[i])) begin
        hit_c = 1'b0;
      end
    end
  end

  // Next-state selection: cfg_load outranks an accepted bit.
  always_comb begin
    pat_d   = pat_q;
    len_d   = len_q;
    ovl_d   = ovl_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    match_d = 1'b0;
    count_d = match_count;
    if (cfg_load) begin
      pat_d   = cfg_pattern;
      len_d   = cfg_len;
      ovl_d   = cfg_overlap;
      hist_d  = '0;
      fill_d  = '0;
      count_d = '0;
    end else if (in_valid) begin
      hist_d  = nh_c;
      match_d = hit_c;
      fill_d  = (hit_c && !ovl_q) ? '0 : nf_c;
      if (hit_c && (match_count != CNT_MAX)) begin
        count_d = match_count + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pat_q       <= DEF_PATTERN;
      len_q       <= LEN_W'(DEF_LEN);
      ovl_q       <= DEF_OVERLAP;
      hist_q      <= '0;
      fill_q      <= '0;
      match       <= 1'b0;
      match_count <= '0;
    end else begin
      pat_q       <= pat_d;
      len_q       <= len_d;
      ovl_q       <= ovl_d;
      hist_q      <= hist_d;
      fill_q      <= fill_d;
      match       <= match_d;
      match_count <= count_d;
    end
  end

  assign count_sat = (match_count == CNT_MAX);

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: directed scenarios plus random traffic,
// all compared against a queue-based reference model.
module tb_seq_detector_param;

  localparam int unsigned MAX_LEN = 8;
  localparam int unsigned LEN_W   = 4;
  localparam int unsigned CNT_W   = 2;
  localparam int          CNT_MAX = (1 << CNT_W) - 1;
  localparam logic [7:0]  DEF_PAT = 8'b0010_0111;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               cfg_load = 1'b0;
  logic [MAX_LEN-1:0] cfg_pattern = '0;
  logic [LEN_W-1:0]   cfg_len = '0;
  logic               cfg_overlap = 1'b0;
  logic               in = 1'b0;
  logic               in_valid = 1'b0;
  logic               match;
  logic [CNT_W-1:0]   match_count;
  logic               count_sat;

  always #5 clk = ~clk;

  seq_detector_param #(
    .MAX_LEN (MAX_LEN),
    .CNT_W   (CNT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .cfg_load    (cfg_load),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .in          (in),
    .in_valid    (in_valid),
    .match       (match),
    .match_count (match_count),
    .count_sat   (count_sat)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: bits received since the last clear point, newest at the back.
  logic [7:0] m_pat = DEF_PAT;
  int         m_len = 6;
  bit         m_ovl = 1'b1;
  bit         q[$];
  int         m_cnt = 0;
  bit         m_match = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_update();
    bit hit;
    if (!reset) begin
      m_pat = DEF_PAT; m_len = 6; m_ovl = 1'b1;
      q.delete(); m_cnt = 0; m_match = 1'b0;
    end else if (cfg_load) begin
      m_pat = cfg_pattern; m_len = int'(cfg_len); m_ovl = cfg_overlap;
      q.delete(); m_cnt = 0; m_match = 1'b0;
    end else if (in_valid) begin
      q.push_back(in);
      if (q.size() > MAX_LEN) void'(q.pop_front());
      hit = (m_len >= 1) && (m_len <= int'(MAX_LEN)) && (q.size() >= m_len);
      if (hit) begin
        for (int k = 0; k < m_len; k++) begin
          if (q[q.size() - 1 - k] != m_pat[k]) hit = 1'b0;
        end
      end
      m_match = hit;
      if (hit) begin
        if (!m_ovl) q.delete();
        if (m_cnt < CNT_MAX) m_cnt++;
      end
    end else begin
      m_match = 1'b0;
    end
  endtask

  task automatic cyc(input logic r, input logic ld, input logic [7:0] p,
                     input logic [3:0] l, input logic o, input logic b, input logic v);
    reset = r; cfg_load = ld; cfg_pattern = p; cfg_len = l; cfg_overlap = o;
    in = b; in_valid = v;
    @(posedge clk);
    model_update();
    #1;
    check("match", 32'(match), 32'(m_match));
    check("match_count", 32'(match_count), 32'(m_cnt));
    check("count_sat", 32'(count_sat), 32'(m_cnt == CNT_MAX));
  endtask

  task automatic feed(input logic b);
    cyc(1'b1, 1'b0, 8'h00, 4'd0, 1'b0, b, 1'b1);
  endtask

  task automatic idle();
    cyc(1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic load(input logic [7:0] p, input logic [3:0] l, input logic o);
    cyc(1'b1, 1'b1, p, l, o, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    cyc(1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [5:0] s1;
    logic [4:0] s2;
    // Reset state
    do_reset();
    do_reset();
    check("rst_match", 32'(match), 32'd0);
    check("rst_count", 32'(match_count), 32'd0);
    check("rst_sat", 32'(count_sat), 32'd0);

    // Default pattern 100111
    s1 = 6'b100111;
    for (int i = 5; i >= 0; i--) begin
      feed(s1[i]);
      check("t1_pulse", 32'(match), (i == 0) ? 32'd1 : 32'd0);
    end
    check("t1_count", 32'(match_count), 32'd1);
    idle();
    check("t1_drop", 32'(match), 32'd0);

    // 101 overlapping, then non-overlapping
    s2 = 5'b10101;
    load(8'b101, 4'd3, 1'b1);
    for (int i = 4; i >= 0; i--) feed(s2[i]);
    check("t2_count", 32'(match_count), 32'd2);
    load(8'b101, 4'd3, 1'b0);
    for (int i = 4; i >= 0; i--) feed(s2[i]);
    check("t3_count", 32'(match_count), 32'd1);

    // Gaps in in_valid
    load(8'b101, 4'd3, 1'b1);
    feed(1'b1); idle(); feed(1'b0); idle(); idle();
    check("t4_nomatch", 32'(match), 32'd0);
    feed(1'b1);
    check("t4_match", 32'(match), 32'd1);
    idle();
    check("t4_drop", 32'(match), 32'd0);
    check("t4_count", 32'(match_count), 32'd1);

    // Reset mid-pattern
    load(8'b101, 4'd3, 1'b1);
    feed(1'b1); feed(1'b0); do_reset(); feed(1'b1);
    check("t5a_match", 32'(match), 32'd0);
    // cfg_load discards same-cycle bit
    load(8'b101, 4'd3, 1'b1);
    feed(1'b1); feed(1'b0);
    cyc(1'b1, 1'b1, 8'b101, 4'd3, 1'b1, 1'b1, 1'b1);
    check("t5b_count", 32'(match_count), 32'd0);
    feed(1'b1);
    check("t5b_match", 32'(match), 32'd0);

    // Saturation with len=1
    load(8'b1, 4'd1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      feed(1'b1);
      check("t6_pulse", 32'(match), 32'd1);
    end
    check("t6_count", 32'(match_count), 32'd3);
    check("t6_sat", 32'(count_sat), 32'd1);
    // Illegal lengths never hit
    load(8'hFF, 4'd0, 1'b1);
    for (int i = 0; i < 6; i++) feed(1'b1);
    check("t6_len0", 32'(match_count), 32'd0);
    load(8'hFF, 4'd9, 1'b1);
    for (int i = 0; i < 10; i++) feed(1'b1);
    check("t6_len9", 32'(match_count), 32'd0);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      int unsigned r;
      logic [3:0] l;
      r = $urandom_range(0, 199);
      l = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 10)) : 4'($urandom_range(1, 4));
      if (r == 0) begin
        do_reset();
      end else if (r < 6) begin
        cyc(1'b1, 1'b1, 8'($urandom), l, 1'($urandom), 1'($urandom), 1'($urandom));
      end else begin
        cyc(1'b1, 1'b0, 8'($urandom), l, 1'($urandom), 1'($urandom),
            ($urandom_range(0, 3) != 0));
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/seq_detector_param.md
# seq_detector_param

Parametrised serial bit-pattern detector. It generalises the team's fixed 6-bit Mealy sequence FSM (pattern 100111) with these additions:
- a runtime-programmable pattern of 1..MAX_LEN bits;
- selectable overlapping or non-overlapping detection;
- an input-valid qualifier;
- a saturating match counter.

It sits between a serial bit source and control logic that reacts to a registered one-cycle match pulse.

## Interface
Parameters:
- MAX_LEN, 8, maximum pattern length in bits (≥2)
- LEN_W, $clog2(MAX_LEN+1), width of length fields
- CNT_W, 8, match counter width
- DEF_PATTERN, 8'b0010_0111, pattern loaded at reset (low MAX_LEN bits used)
- DEF_LEN, 6, length loaded at reset
- DEF_OVERLAP, 1, overlap mode at reset

Ports:
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-low reset; sampled on rising clk
- cfg_load  in  1  strobe: latch cfg_pattern/cfg_len/cfg_overlap
- cfg_pattern  in  MAX_LEN  pattern; bit [len-1] is the first-received bit, bit [0] the last
- cfg_len  in  LEN_W  pattern length; legal range 1..MAX_LEN
- cfg_overlap  in  1  1 = overlapping matches allowed, 0 = non-overlapping
- in  in  1  serial data bit
- in_valid  in  1  in is accepted on a rising edge only when high
- match  out  1  registered one-cycle pulse per detected pattern
- match_count  out  CNT_W  matches since last reset/cfg_load, saturating
- count_sat  out  1  high while match_count = 2^CNT_W-1

## Operation
Internal registers:
- pat, len, ovl: active configuration.
- hist[MAX_LEN-1:0]: shift history; the newest bit is hist[0].
- fill: count of valid history bits, 0..MAX_LEN.

Reset (reset=0 at an edge):
- pat=DEF_PATTERN, len=DEF_LEN, ovl=DEF_OVERLAP.
- hist=0, fill=0.
- match=0, match_count=0, count_sat=0.
- Reset overrides every other input.

cfg_load=1 (reset=1):
- Latch the configuration.
- Clear hist, fill, match and match_count.
- A same-cycle in_valid bit is discarded.
- cfg_load has priority over in_valid.

Accepted bit (in_valid=1, no cfg_load, no reset):
- nh = {hist[MAX_LEN-2:0], in}.
- nf = min(fill+1, MAX_LEN).
- hit = (len in 1..MAX_LEN) && (nf ≥ len) && (nh[len-1:0] == pat[len-1:0]).
- Update: hist ← nh; match ← hit.
- Fill update: if hit and ovl=0, fill ← 0 (matched bits are consumed); otherwise fill ← nf.
- If hit and match_count is not saturated, match_count increments by 1.

Other conditions:
- in_valid=0: hist, fill and match_count hold; match ← 0.
- Illegal len (0 or >MAX_LEN): hit is never asserted. Shifting and fill continue normally.
- Pattern bits above len-1 are ignored.
- match_count saturates at 2^CNT_W-1 and never wraps.
- count_sat = (match_count == all-ones). It is combinational from the register.

## Timing
- Latency: match rises in the cycle after the edge that accepts the final pattern bit. It is high for exactly one cycle per hit.
- Back-to-back hits (overlap mode, periodic pattern) produce match high on consecutive cycles.
- match_count updates on the same edge that sets match.
- Configuration takes effect from the first accepted bit after the cfg_load edge.
- There is no backpressure; every in_valid cycle is consumed.

## Test plan
1. Default config after reset; stream 1,0,0,1,1,1 with in_valid=1 throughout → match=1 only in the cycle after bit 6; match_count=1.
2. cfg_load pattern=3'b101, len=3, overlap=1; stream 1,0,1,0,1 → match pulses after bits 3 and 5; match_count=2.
3. Same as scenario 2 but overlap=0 → single match after bit 3; match_count=1.
4. Pattern 101, stream with in_valid=0 gaps between the bits 1 _ 0 _ _ 1 → exactly one match, one cycle after the accepting edge; no match during the gaps.
5. Reset and cfg_load mid-operation:
   - Feed 1,0 of pattern 101, assert reset=0 for one edge, then feed 1 → no match.
   - Repeat, but with cfg_load plus in_valid=1 in the same cycle → that bit is discarded and match_count=0.
6. Saturation and illegal length:
   - CNT_W=2, pattern 1'b1 with len=1 and overlap=1; stream 1,1,1,1,1 → match high 5 consecutive cycles; match_count stops at 3; count_sat=1.
   - Then cfg_load len=0; stream all 1s → match never asserts.
